// File: rtl/shift_left_logical_seq.sv
// Multi-cycle logical left shifter (SLL/SLLI, optional SLLW/SLLIW) for the RV64 ALU.
// One log-stage per cycle, MSB stage first, with valid/ready handshakes on both sides.
module shift_left_logical_seq #(
  parameter int XLEN    = 64,
  parameter int SHW     = $clog2(XLEN),
  parameter bit WORD_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_a,
  input  logic [SHW-1:0]  in_shamt,
  input  logic            in_word,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result
);

  localparam int STW = (SHW > 1) ? $clog2(SHW) : 1;
  // Word ops only make sense on a 64-bit datapath.
  localparam logic WORD_OK = WORD_EN && (XLEN == 64);
  localparam logic [SHW-1:0] WORD_MASK = {1'b0, {(SHW-1){1'b1}}};
  localparam logic [STW-1:0] LAST_STAGE = STW'(SHW - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e          state_r;
  logic [XLEN-1:0] acc_r;
  logic [SHW-1:0]  amt_r;
  logic            wd_r;
  logic [STW-1:0]  stage_r;

  logic            word_s;
  logic [SHW-1:0]  amt_in_s;
  logic [SHW-1:0]  dist_s;
  logic [XLEN-1:0] acc_nxt_s;
  logic [XLEN-1:0] result_nxt_s;

  // Sign-extend the low 32 bits of a value to the full datapath width.
  function automatic logic [XLEN-1:0] sext_word(input logic [XLEN-1:0] v);
    logic [XLEN-1:0] r;
    for (int i = 0; i < XLEN; i++) begin
      r[i] = (i < 32) ? v[i] : v[31];
    end
    return r;
  endfunction

  assign word_s   = in_word & WORD_OK;
  assign amt_in_s = word_s ? (in_shamt & WORD_MASK) : in_shamt;

  // One log-stage of the shift plus the final result formatting.
  always_comb begin
    dist_s    = SHW'(1) << stage_r;
    acc_nxt_s = acc_r;
    if (amt_r[stage_r]) begin
      acc_nxt_s = acc_r << dist_s;
    end else begin
      acc_nxt_s = acc_r;
    end
    result_nxt_s = wd_r ? sext_word(acc_nxt_s) : acc_nxt_s;
  end

  // Control FSM, datapath registers and registered handshake/result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      acc_r      <= {XLEN{1'b0}};
      amt_r      <= {SHW{1'b0}};
      wd_r       <= 1'b0;
      stage_r    <= {STW{1'b0}};
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      out_result <= {XLEN{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            acc_r    <= in_a;
            amt_r    <= amt_in_s;
            wd_r     <= word_s;
            stage_r  <= LAST_STAGE;
            in_ready <= 1'b0;
            state_r  <= ST_SHIFT;
          end else begin
            in_ready <= 1'b1;
          end
        end
        ST_SHIFT: begin
          acc_r <= acc_nxt_s;
          if (stage_r == STW'(0)) begin
            // Result is captured on the last stage edge so it is ready with out_valid.
            out_result <= result_nxt_s;
            out_valid  <= 1'b1;
            state_r    <= ST_DONE;
          end else begin
            stage_r <= stage_r - STW'(1);
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_r   <= ST_IDLE;
          end else begin
            out_valid <= 1'b1;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
